// File: rtl/pipeline_ctrl_pkg.sv
// Shared LC-3b types for the pipeline controller: register/word types, FSM state, counter width.
package lc3b_types;

  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    RUN,
    DMEM_WAIT
  } pipe_state_t;

  localparam int STAT_WIDTH_DEF = 16;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Status inputs and stage-register load controls between the datapath and pipeline_ctrl.
interface pipeline_ctrl_if;
  import lc3b_types::*;

  logic    de_valid;
  lc3b_reg de_sr1;
  lc3b_reg de_sr2;
  logic    de_uses_sr1;
  logic    de_uses_sr2;
  logic    ex_valid;
  logic    ex_is_load;
  logic    ex_br_taken;
  lc3b_reg ex_dest;
  logic    imem_resp;
  logic    mem_valid;
  logic    mem_access;
  logic    dmem_resp;

  logic    load_pc;
  logic    load_de;
  logic    load_ex;
  logic    load_mem;
  logic    load_wb;
  logic    de_valid_in;
  logic    ex_valid_in;
  logic    wb_valid_in;

  modport master (
    input  de_valid, de_sr1, de_sr2, de_uses_sr1, de_uses_sr2,
           ex_valid, ex_is_load, ex_br_taken, ex_dest,
           imem_resp, mem_valid, mem_access, dmem_resp,
    output load_pc, load_de, load_ex, load_mem, load_wb,
           de_valid_in, ex_valid_in, wb_valid_in
  );

  modport slave (
    output de_valid, de_sr1, de_sr2, de_uses_sr1, de_uses_sr2,
           ex_valid, ex_is_load, ex_br_taken, ex_dest,
           imem_resp, mem_valid, mem_access, dmem_resp,
    input  load_pc, load_de, load_ex, load_mem, load_wb,
           de_valid_in, ex_valid_in, wb_valid_in
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds a source read by decode.
module hazard_detect
  import lc3b_types::*;
(
  input  logic    de_valid,
  input  lc3b_reg de_sr1,
  input  lc3b_reg de_sr2,
  input  logic    de_uses_sr1,
  input  logic    de_uses_sr2,
  input  logic    ex_valid,
  input  logic    ex_is_load,
  input  lc3b_reg ex_dest,
  output logic    load_use
);

  assign load_use = de_valid & ex_valid & ex_is_load &
                    ((de_uses_sr1 & (de_sr1 == ex_dest)) |
                     (de_uses_sr2 & (de_sr2 == ex_dest)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the LC-3b 5-stage pipeline; priority dmem wait > flush > load-use > imem stall.
// Optional saturating stall/flush counters are built only when PIPE_PERF_EN is defined.
module pipeline_ctrl
  import lc3b_types::*;
#(
  parameter int STAT_WIDTH = STAT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_ctrl_if.master       pif
`ifdef PIPE_PERF_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_stall,
  output logic [STAT_WIDTH-1:0] stat_flush
`endif
);

  if (STAT_WIDTH < 1) begin : g_bad_width
    $error("pipeline_ctrl: STAT_WIDTH must be at least 1");
  end

  pipe_state_t state, state_next;
  logic        dmem_wait;
  logic        flush;
  logic        load_use;

  hazard_detect u_hazard (
    .de_valid    (pif.de_valid),
    .de_sr1      (pif.de_sr1),
    .de_sr2      (pif.de_sr2),
    .de_uses_sr1 (pif.de_uses_sr1),
    .de_uses_sr2 (pif.de_uses_sr2),
    .ex_valid    (pif.ex_valid),
    .ex_is_load  (pif.ex_is_load),
    .ex_dest     (pif.ex_dest),
    .load_use    (load_use)
  );

  assign dmem_wait = pif.mem_valid & pif.mem_access & ~pif.dmem_resp;
  assign flush     = pif.ex_valid & pif.ex_br_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // A branch held in EX during a data wait is not latched: it is still presented
  // by the datapath on the resp cycle, where the flush branch below applies it.
  always_comb begin
    state_next      = state;
    pif.load_pc     = 1'b1;
    pif.load_de     = 1'b1;
    pif.load_ex     = 1'b1;
    pif.load_mem    = 1'b1;
    pif.load_wb     = 1'b1;
    pif.de_valid_in = pif.imem_resp;
    pif.ex_valid_in = pif.de_valid;
    pif.wb_valid_in = pif.mem_valid;

    case (state)
      RUN:       if (dmem_wait)     state_next = DMEM_WAIT;
      DMEM_WAIT: if (pif.dmem_resp) state_next = RUN;
      default:                      state_next = RUN;
    endcase

    if (reset) begin
      pif.de_valid_in = 1'b0;
      pif.ex_valid_in = 1'b0;
      pif.wb_valid_in = 1'b0;
    end else if (dmem_wait) begin
      pif.load_pc     = 1'b0;
      pif.load_de     = 1'b0;
      pif.load_ex     = 1'b0;
      pif.load_mem    = 1'b0;
      pif.wb_valid_in = 1'b0;
    end else if (flush) begin
      pif.de_valid_in = 1'b0;
      pif.ex_valid_in = 1'b0;
    end else if (load_use) begin
      pif.load_pc     = 1'b0;
      pif.load_de     = 1'b0;
      pif.ex_valid_in = 1'b0;
    end else if (!pif.imem_resp) begin
      pif.load_pc     = 1'b0;
      pif.de_valid_in = 1'b0;
    end
  end

`ifdef PIPE_PERF_EN
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stall <= '0;
      stat_flush <= '0;
    end else begin
      if (!pif.load_pc || !pif.load_de) stat_stall <= sat_inc(stat_stall);
      if (flush && !dmem_wait)          stat_flush <= sat_inc(stat_flush);
    end
  end
`endif

endmodule
